// File: rtl/mips_pkg.sv
// Shared types and helpers for the MIPS memory-access stage.
package mips_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LBU  = 4'd2,
    MEM_LH   = 4'd3,
    MEM_LHU  = 4'd4,
    MEM_LW   = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  localparam logic [3:0] BE_BYTE    = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // Per-instruction bookkeeping carried from accept to write-back.
  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] inst;
    logic              write_reg;
    logic [REG_W-1:0]  write_dst;
  } wb_tag_t;

  // Unused encodings collapse onto NONE.
  function automatic mem_op_e decode_op(input logic [3:0] raw);
    return (raw > 4'd8) ? MEM_NONE : mem_op_e'(raw);
  endfunction

  function automatic logic is_load(input mem_op_e op);
    return op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW};
  endfunction

  function automatic logic is_store(input mem_op_e op);
    return op inside {MEM_SB, MEM_SH, MEM_SW};
  endfunction

  function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] lo);
    logic half_op;
    logic word_op;
    half_op = op inside {MEM_LH, MEM_LHU, MEM_SH};
    word_op = op inside {MEM_LW, MEM_SW};
    return (half_op && lo[0]) || (word_op && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX-side, data-memory and WB-side signals of the memory-access stage.
interface mem_stage_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       PC_in;
  logic [31:0]       Inst_in;
  logic [3:0]        mem_op;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       store_data;
  logic              write_reg_in;
  logic [4:0]        write_dst_in;
  logic              flush;

  logic              dm_req;
  logic              dm_we;
  logic [3:0]        dm_be;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_wdata;
  logic              dm_ack;
  logic [31:0]       dm_rdata;

  logic              out_valid;
  logic [31:0]       PC_out;
  logic [31:0]       Inst_out;
  logic [31:0]       mem_ext_data;
  logic              write_reg_out;
  logic [4:0]        write_dst_out;
  logic              load_addr_fault;
  logic              store_addr_fault;
  logic [31:0]       badVaddr;

  // Environment side: EX stage, data memory and WB stage.
  modport master (
    output in_valid, PC_in, Inst_in, mem_op, addr, store_data,
           write_reg_in, write_dst_in, flush, dm_ack, dm_rdata,
    input  in_ready, dm_req, dm_we, dm_be, dm_addr, dm_wdata,
           out_valid, PC_out, Inst_out, mem_ext_data, write_reg_out,
           write_dst_out, load_addr_fault, store_addr_fault, badVaddr
  );

  // The memory stage itself.
  modport slave (
    input  in_valid, PC_in, Inst_in, mem_op, addr, store_data,
           write_reg_in, write_dst_in, flush, dm_ack, dm_rdata,
    output in_ready, dm_req, dm_we, dm_be, dm_addr, dm_wdata,
           out_valid, PC_out, Inst_out, mem_ext_data, write_reg_out,
           write_dst_out, load_addr_fault, store_addr_fault, badVaddr
  );
endinterface

// File: rtl/mem_lane_align.sv
// Little-endian byte-lane steering: store replication/byte enables and
// load lane select with sign/zero extension. Purely combinational.
module mem_lane_align
  import mips_pkg::*;
(
  input  mem_op_e           op_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [DATA_W-1:0] store_data_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [3:0]        be_c_o,
  output logic [DATA_W-1:0] wdata_c_o,
  output logic [DATA_W-1:0] ext_c_o
);

  logic [DATA_W-1:0] shifted_c;
  logic [7:0]        byte_c;
  logic [15:0]       half_c;

  always_comb begin
    be_c_o    = 4'b0000;
    wdata_c_o = store_data_i;
    case (op_i)
      MEM_LB, MEM_LBU, MEM_SB: be_c_o = 4'(BE_BYTE << addr_lo_i);
      MEM_LH, MEM_LHU, MEM_SH: be_c_o = addr_lo_i[1] ? BE_HALF_HI : BE_HALF_LO;
      MEM_LW, MEM_SW:          be_c_o = BE_WORD;
      default:                 be_c_o = 4'b0000;
    endcase
    case (op_i)
      MEM_SB:  wdata_c_o = {4{store_data_i[7:0]}};
      MEM_SH:  wdata_c_o = {2{store_data_i[15:0]}};
      default: wdata_c_o = store_data_i;
    endcase
  end

  // Half lane ignores addr[0], so misaligned halves land on the aligned half.
  always_comb begin
    shifted_c = rdata_i >> {addr_lo_i, 3'b000};
    byte_c    = shifted_c[7:0];
    half_c    = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (op_i)
      MEM_LB:  ext_c_o = {{24{byte_c[7]}}, byte_c};
      MEM_LBU: ext_c_o = {24'h000000, byte_c};
      MEM_LH:  ext_c_o = {{16{half_c[15]}}, half_c};
      MEM_LHU: ext_c_o = {16'h0000, half_c};
      MEM_LW:  ext_c_o = rdata_i;
      default: ext_c_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: req/ack data-memory port, load extension and
// registered WB outputs. MEM_ADDR_FAULT_EN enables misaligned-access faults.
module mem_stage
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  mem_stage_if.slave bus
);

  state_e            state_q, state_d;
  mem_op_e           in_op_c, align_op_c, op_q, op_d;
  logic [1:0]        align_lo_c, lo_q, lo_d;
  wb_tag_t           tag_q, tag_d, out_tag_q, out_tag_d;
  logic              squash_q, squash_d;
  logic              dm_req_q, dm_req_d, dm_we_q, dm_we_d;
  logic [3:0]        dm_be_q, dm_be_d;
  logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
  logic [DATA_W-1:0] dm_wdata_q, dm_wdata_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] mem_ext_q, mem_ext_d, badvaddr_q, badvaddr_d;
  logic              ld_fault_q, ld_fault_d, st_fault_q, st_fault_d;
  logic              accept_c, fault_c, mem_go_c, retire_now_c;
  logic [3:0]        lane_be_c;
  logic [DATA_W-1:0] lane_wdata_c, lane_ext_c;

  assign in_op_c  = decode_op(bus.mem_op);
  assign accept_c = bus.in_valid && (state_q == ST_IDLE) && !bus.flush;
`ifdef MEM_ADDR_FAULT_EN
  assign fault_c  = is_misaligned(in_op_c, bus.addr[1:0]);
`else
  assign fault_c  = 1'b0;
`endif
  assign mem_go_c     = accept_c && (in_op_c != MEM_NONE) && !fault_c;
  assign retire_now_c = accept_c && !mem_go_c;

  // Store path steers the incoming op; load path the captured one.
  assign align_op_c = (state_q == ST_IDLE) ? in_op_c : op_q;
  assign align_lo_c = (state_q == ST_IDLE) ? bus.addr[1:0] : lo_q;

  mem_lane_align u_align (
    .op_i         (align_op_c),
    .addr_lo_i    (align_lo_c),
    .store_data_i (bus.store_data),
    .rdata_i      (bus.dm_rdata),
    .be_c_o       (lane_be_c),
    .wdata_c_o    (lane_wdata_c),
    .ext_c_o      (lane_ext_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mem_go_c)    state_d = ST_WAIT;
      ST_WAIT: if (bus.dm_ack)  state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dm_req_d    = dm_req_q;
    dm_we_d     = dm_we_q;
    dm_be_d     = dm_be_q;
    dm_addr_d   = dm_addr_q;
    dm_wdata_d  = dm_wdata_q;
    op_d        = op_q;
    lo_d        = lo_q;
    tag_d       = tag_q;
    squash_d    = squash_q;
    out_valid_d = 1'b0;
    out_tag_d   = out_tag_q;
    mem_ext_d   = mem_ext_q;
    ld_fault_d  = ld_fault_q;
    st_fault_d  = st_fault_q;
    badvaddr_d  = badvaddr_q;
    case (state_q)
      ST_IDLE: begin
        if (retire_now_c) begin
          out_valid_d         = 1'b1;
          out_tag_d.pc        = bus.PC_in;
          out_tag_d.inst      = bus.Inst_in;
          out_tag_d.write_reg = bus.write_reg_in && !fault_c;
          out_tag_d.write_dst = bus.write_dst_in;
          mem_ext_d           = '0;
          ld_fault_d          = fault_c && is_load(in_op_c);
          st_fault_d          = fault_c && is_store(in_op_c);
          badvaddr_d          = fault_c ? 32'(bus.addr) : '0;
        end else if (mem_go_c) begin
          dm_req_d        = 1'b1;
          dm_we_d         = is_store(in_op_c);
          dm_be_d         = lane_be_c;
          dm_addr_d       = {bus.addr[ADDR_W-1:2], 2'b00};
          dm_wdata_d      = lane_wdata_c;
          op_d            = in_op_c;
          lo_d            = bus.addr[1:0];
          tag_d.pc        = bus.PC_in;
          tag_d.inst      = bus.Inst_in;
          tag_d.write_reg = bus.write_reg_in && !is_store(in_op_c);
          tag_d.write_dst = bus.write_dst_in;
          squash_d        = 1'b0;
        end
      end
      ST_WAIT: begin
        if (bus.flush) squash_d = 1'b1;
        // The bus request cannot be aborted; a squash only suppresses the retire.
        if (bus.dm_ack) begin
          dm_req_d   = 1'b0;
          squash_d   = 1'b0;
          ld_fault_d = 1'b0;
          st_fault_d = 1'b0;
          badvaddr_d = '0;
          if (squash_q || bus.flush) begin
            out_tag_d.write_reg = 1'b0;
          end else begin
            out_valid_d = 1'b1;
            out_tag_d   = tag_q;
            mem_ext_d   = is_load(op_q) ? lane_ext_c : '0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dm_req_q    <= 1'b0;
      dm_we_q     <= 1'b0;
      dm_be_q     <= 4'b0000;
      dm_addr_q   <= '0;
      dm_wdata_q  <= '0;
      op_q        <= MEM_NONE;
      lo_q        <= 2'b00;
      tag_q       <= '0;
      squash_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      mem_ext_q   <= '0;
      ld_fault_q  <= 1'b0;
      st_fault_q  <= 1'b0;
      badvaddr_q  <= '0;
    end else begin
      dm_req_q    <= dm_req_d;
      dm_we_q     <= dm_we_d;
      dm_be_q     <= dm_be_d;
      dm_addr_q   <= dm_addr_d;
      dm_wdata_q  <= dm_wdata_d;
      op_q        <= op_d;
      lo_q        <= lo_d;
      tag_q       <= tag_d;
      squash_q    <= squash_d;
      out_valid_q <= out_valid_d;
      out_tag_q   <= out_tag_d;
      mem_ext_q   <= mem_ext_d;
      ld_fault_q  <= ld_fault_d;
      st_fault_q  <= st_fault_d;
      badvaddr_q  <= badvaddr_d;
    end
  end

  assign bus.in_ready         = (state_q == ST_IDLE);
  assign bus.dm_req           = dm_req_q;
  assign bus.dm_we            = dm_we_q;
  assign bus.dm_be            = dm_be_q;
  assign bus.dm_addr          = dm_addr_q;
  assign bus.dm_wdata         = dm_wdata_q;
  assign bus.out_valid        = out_valid_q;
  assign bus.PC_out           = out_tag_q.pc;
  assign bus.Inst_out         = out_tag_q.inst;
  assign bus.mem_ext_data     = mem_ext_q;
  assign bus.write_reg_out    = out_tag_q.write_reg;
  assign bus.write_dst_out    = out_tag_q.write_dst;
  assign bus.load_addr_fault  = ld_fault_q;
  assign bus.store_addr_fault = st_fault_q;
  assign bus.badVaddr         = badvaddr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed plus randomized bench for mem_stage against a byte-level memory model.
module tb_mem_stage;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

`ifdef MEM_ADDR_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  mem_stage_if #(.ADDR_W(32)) bus ();

  mem_stage #(.ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] mem [int unsigned];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] wa);
    if (!mem.exists(wa)) mem[wa] = $urandom;
    return mem[wa];
  endfunction

  function automatic int size_of(input int op);
    case (op)
      1, 2, 6: return 1;
      3, 4, 7: return 2;
      5, 8:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit is_ld(input int op); return op >= 1 && op <= 5; endfunction
  function automatic bit is_st(input int op); return op >= 6 && op <= 8; endfunction

  function automatic bit misal(input int op, input logic [31:0] a);
    int s = size_of(op);
    return s > 1 && (int'(a % 4) % s) != 0;
  endfunction

  // Byte offset of the accessed item inside its word, rounded down to its size.
  function automatic int lane_off(input int op, input logic [31:0] a);
    int s = size_of(op);
    int o = int'(a % 4);
    return o - (o % s);
  endfunction

  function automatic logic [3:0] exp_be(input int op, input logic [31:0] a);
    int s = size_of(op);
    return 4'(((1 << s) - 1) << lane_off(op, a));
  endfunction

  function automatic logic [31:0] exp_wdata(input int op, input logic [31:0] sd);
    case (size_of(op))
      1:       return 32'(sd[7:0]) * 32'h01010101;
      2:       return 32'(sd[15:0]) * 32'h00010001;
      default: return sd;
    endcase
  endfunction

  function automatic logic [31:0] exp_ext(input int op, input logic [31:0] a, input logic [31:0] word);
    int s = size_of(op);
    longint unsigned w = 64'(word);
    longint unsigned v;
    v = (w >> (8 * lane_off(op, a))) & ((64'd1 << (8 * s)) - 64'd1);
    if ((op == 1 || op == 3) && ((v >> (8 * s - 1)) & 64'd1) == 64'd1)
      v = v - (64'd1 << (8 * s));
    return 32'(v);
  endfunction

  // Issue one instruction, play memory with ack latency k, flush on WAIT cycle fl (0 = none).
  task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] sd,
                        input bit wr, input logic [4:0] dst, input int k, input int fl);
    int          eop  = (op > 8) ? 0 : op;
    bit          flt  = FAULT_EN && misal(eop, a);
    bit          memop = (eop != 0) && !flt;
    bit          squashed;
    logic [31:0] pc   = $urandom;
    logic [31:0] inst = $urandom;
    logic [31:0] wa   = {a[31:2], 2'b00};
    logic [31:0] wd   = exp_wdata(eop, sd);
    logic [3:0]  be   = exp_be(eop, a);
    logic [31:0] word;
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1; bus.PC_in = pc; bus.Inst_in = inst; bus.mem_op = 4'(op);
    bus.addr = a; bus.store_data = sd; bus.write_reg_in = wr; bus.write_dst_in = dst;
    step();
    bus.in_valid = 1'b0; bus.PC_in = $urandom; bus.Inst_in = $urandom; bus.mem_op = 4'($urandom);
    bus.addr = $urandom; bus.store_data = $urandom; bus.write_reg_in = 1'($urandom);
    bus.write_dst_in = 5'($urandom);
    if (memop) begin
      word = mem_rd(wa);
      for (int i = 1; i <= k; i++) begin
        chk("dm_req_held", 32'(bus.dm_req), 32'd1);
        chk("in_ready_wait", 32'(bus.in_ready), 32'd0);
        chk("out_valid_wait", 32'(bus.out_valid), 32'd0);
        chk("dm_we", 32'(bus.dm_we), 32'(is_st(eop)));
        chk("dm_be", 32'(bus.dm_be), 32'(be));
        chk("dm_addr", bus.dm_addr, wa);
        if (is_st(eop)) chk("dm_wdata", bus.dm_wdata, wd);
        bus.flush = (i == fl);
        if (i == k) begin
          bus.dm_ack = 1'b1;
          bus.dm_rdata = word;
        end
        step();
      end
      bus.dm_ack = 1'b0; bus.flush = 1'b0; bus.dm_rdata = $urandom;
      if (is_st(eop))
        for (int b = 0; b < 4; b++)
          if (be[b]) mem[wa][8*b +: 8] = wd[8*b +: 8];
      squashed = (fl >= 1 && fl <= k);
      chk("out_valid_mem", 32'(bus.out_valid), 32'(!squashed));
      chk("in_ready_after_ack", 32'(bus.in_ready), 32'd1);
      chk("dm_req_dropped", 32'(bus.dm_req), 32'd0);
      chk("write_reg_mem", 32'(bus.write_reg_out), 32'(!squashed && is_ld(eop) && wr));
      chk("ld_fault_mem", 32'(bus.load_addr_fault), 32'd0);
      chk("st_fault_mem", 32'(bus.store_addr_fault), 32'd0);
      chk("badvaddr_mem", bus.badVaddr, 32'd0);
      if (!squashed) begin
        chk("pc_out_mem", bus.PC_out, pc);
        chk("inst_out_mem", bus.Inst_out, inst);
        chk("dst_out_mem", 32'(bus.write_dst_out), 32'(dst));
        chk("mem_ext_data", bus.mem_ext_data, is_ld(eop) ? exp_ext(eop, a, word) : 32'd0);
      end
    end else begin
      chk("out_valid_fast", 32'(bus.out_valid), 32'd1);
      chk("dm_req_none", 32'(bus.dm_req), 32'd0);
      chk("in_ready_fast", 32'(bus.in_ready), 32'd1);
      chk("pc_out_fast", bus.PC_out, pc);
      chk("inst_out_fast", bus.Inst_out, inst);
      chk("dst_out_fast", 32'(bus.write_dst_out), 32'(dst));
      chk("write_reg_fast", 32'(bus.write_reg_out), 32'(wr && !flt));
      chk("mem_ext_fast", bus.mem_ext_data, 32'd0);
      chk("ld_fault", 32'(bus.load_addr_fault), 32'(flt && is_ld(eop)));
      chk("st_fault", 32'(bus.store_addr_fault), 32'(flt && is_st(eop)));
      chk("badvaddr", bus.badVaddr, flt ? a : 32'd0);
    end
    step();
    chk("out_valid_pulse_end", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] pcs [4];
    int op, k, fl;
    logic [31:0] a;
    rst_n = 1'b1;
    bus.in_valid = 1'b0; bus.PC_in = '0; bus.Inst_in = '0; bus.mem_op = 4'd0;
    bus.addr = '0; bus.store_data = '0; bus.write_reg_in = 1'b0; bus.write_dst_in = 5'd0;
    bus.flush = 1'b0; bus.dm_ack = 1'b0; bus.dm_rdata = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_dm_req", 32'(bus.dm_req), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_ld_fault", 32'(bus.load_addr_fault), 32'd0);
    chk("rst_st_fault", 32'(bus.store_addr_fault), 32'd0);
    chk("rst_badvaddr", bus.badVaddr, 32'd0);
    chk("rst_mem_ext", bus.mem_ext_data, 32'd0);
    chk("rst_pc_out", bus.PC_out, 32'd0);
    chk("rst_dm_be", 32'(bus.dm_be), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();

    // LB sign extension from the top byte lane.
    mem[32'h1000] = 32'h80123456;
    run_op(1, 32'h1003, 32'h0, 1'b1, 5'd3, 1, 0);
    chk("lb_sign_const", bus.mem_ext_data, 32'hFFFFFF80);

    // SH to the upper half with a slow ack.
    run_op(7, 32'h2002, 32'h0000BEEF, 1'b1, 5'd4, 3, 0);
    chk("sh_write_reg", 32'(bus.write_reg_out), 32'd0);
    chk("sh_mem_image", mem[32'h2000][31:16], 32'h0000BEEF);

    // Misaligned LW: faulting retire or aligned access depending on the build.
    mem[32'h3000] = 32'hCAFEF00D;
    run_op(5, 32'h3001, 32'h0, 1'b1, 5'd5, 1, 0);
    chk("lw_misal", FAULT_EN ? bus.badVaddr : bus.mem_ext_data, FAULT_EN ? 32'h3001 : 32'hCAFEF00D);

    // Flush in WAIT, then flush coinciding with ack.
    run_op(5, 32'h4000, 32'h0, 1'b1, 5'd6, 3, 2);
    run_op(3, 32'h4002, 32'h0, 1'b1, 5'd7, 2, 2);
    run_op(0, 32'h0, 32'h0, 1'b1, 5'd8, 1, 0);

    // Flush in IDLE discards the instruction.
    bus.in_valid = 1'b1; bus.mem_op = 4'd5; bus.addr = 32'h5000; bus.flush = 1'b1;
    step();
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    chk("idle_flush_req", 32'(bus.dm_req), 32'd0);
    chk("idle_flush_valid", 32'(bus.out_valid), 32'd0);
    chk("idle_flush_ready", 32'(bus.in_ready), 32'd1);

    // Back-to-back NONE ops.
    for (int i = 0; i < 4; i++) begin
      pcs[i] = $urandom;
      bus.in_valid = 1'b1; bus.mem_op = 4'd0; bus.PC_in = pcs[i]; bus.Inst_in = ~pcs[i];
      bus.write_reg_in = 1'b1; bus.write_dst_in = 5'(i);
      step();
      chk("b2b_valid", 32'(bus.out_valid), 32'd1);
      chk("b2b_pc", bus.PC_out, pcs[i]);
      chk("b2b_inst", bus.Inst_out, ~pcs[i]);
      chk("b2b_ext", bus.mem_ext_data, 32'd0);
    end
    bus.in_valid = 1'b0;
    step();
    chk("b2b_end", 32'(bus.out_valid), 32'd0);

    // Randomized mix.
    for (int n = 0; n < 80; n++) begin
      op = $urandom_range(0, 15);
      a  = {20'($urandom_range(0, 3)), 10'($urandom), 2'($urandom)};
      k  = $urandom_range(1, 3);
      fl = ($urandom_range(0, 5) == 0) ? $urandom_range(1, k) : 0;
      run_op(op, a, $urandom, 1'($urandom), 5'($urandom), k, fl);
    end

    // Asynchronous reset while waiting on the memory.
    bus.in_valid = 1'b1; bus.mem_op = 4'd5; bus.addr = 32'h6000; bus.write_reg_in = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("rst_wait_req_before", 32'(bus.dm_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wait_req", 32'(bus.dm_req), 32'd0);
    chk("rst_wait_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_wait_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_wait_pc", bus.PC_out, 32'd0);
    chk("rst_wait_ext", bus.mem_ext_data, 32'd0);
    chk("rst_wait_wreg", 32'(bus.write_reg_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_op(2, 32'h1003, 32'h0, 1'b1, 5'd9, 1, 0);
    chk("post_rst_lbu", bus.mem_ext_data, 32'h00000080);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage MIPS pipeline, sitting between EX and WB. It takes the EX result (address, store data, destination) and drives a req/ack data-memory port with byte enables. It sign- or zero-extends load data and flags misaligned accesses. Each completed instruction is registered and presented to the write-back stage as `mem_ext_data`, `write_reg_out` and `write_dst_out`.

## Interface
Parameters:
- `ADDR_W`, 32: data address width.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: EX presents an instruction.
- `in_ready` out 1: stage can accept; high only in IDLE.
- `PC_in`, `Inst_in` in 32: passed through to WB.
- `mem_op` in 4: access type, encoded as `mem_op_e`.
- `addr` in ADDR_W: effective address (EX ALU result).
- `store_data` in 32: rt value.
- `write_reg_in` in 1: register write enable.
- `write_dst_in` in 5: destination register.
- `flush` in 1: squash the current instruction.
- `dm_req` out 1: memory request.
- `dm_we` out 1: store when 1.
- `dm_be` out 4: byte enables.
- `dm_addr` out ADDR_W: word-aligned address (`[1:0]` = 0).
- `dm_wdata` out 32: lane-replicated store data.
- `dm_ack` in 1: access done; `dm_rdata` is valid in the same cycle.
- `dm_rdata` in 32: read data.
- `out_valid` out 1: WB-side registers hold a retired instruction this cycle.
- `PC_out`, `Inst_out` out 32: registered pass-through.
- `mem_ext_data` out 32: extended load data; 0 for non-loads.
- `write_reg_out` out 1: register write enable to WB.
- `write_dst_out` out 5: destination register to WB.
- `load_addr_fault`, `store_addr_fault` out 1: misaligned access.
- `badVaddr` out 32: faulting address; 0 otherwise.

## Operation
- `mem_op_e`: NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, SB=6, SH=7, SW=8. Codes 9–15 are treated as NONE.
- FSM has two states, IDLE and WAIT.
  - **IDLE, handshake.** A handshake occurs when `in_valid && in_ready`.
  - **IDLE, NONE or faulting op.** The output registers load next edge, `out_valid`=1, no `dm_req`. Stay in IDLE.
  - **IDLE, memory op.** Capture request registers and go to WAIT. `dm_req`=1 from the next cycle.
  - **WAIT.** Hold `dm_req`, `dm_we`, `dm_be`, `dm_addr` and `dm_wdata` stable until `dm_ack`. On ack, load the output registers and set `out_valid`=1 next edge, then return to IDLE.
- `out_valid` is a one-cycle pulse per retired instruction; otherwise 0. Output data registers hold their last value.
- Byte lanes are little-endian and set by `addr[1:0]`.
  - SB: `be`=1<<a, byte replicated ×4.
  - SH: `be`=`a[1]`?1100:0011, half replicated ×2.
  - SW: `be`=1111.
- Loads select the lane the same way. LB/LH sign-extend; LBU/LHU zero-extend.
- A store retires with `write_reg_out`=0.
- **Flush in IDLE.** The input is discarded; nothing is captured.
- **Flush in WAIT.** The pending flag is marked squashed. `dm_req` is still held to ack, because bus requests are not abortable. At retire, `write_reg_out`=0, the fault flags are 0 and `out_valid`=0.
- A flush arriving in the same cycle as `dm_ack` squashes that retire.
- **Reset mid-WAIT.** Return to IDLE and drop `dm_req` immediately (asynchronous). The memory side must tolerate an abandoned request.

## Timing
- **Reset values.**
  - All registered outputs are 0, including `dm_req`, `out_valid`, the fault flags and `badVaddr`.
  - State is IDLE, so `in_ready`=1.
- **Non-memory or faulting op.** Accepted at edge N, `out_valid` high in cycle N+1.
- **Memory op.** Accepted at edge N, `dm_req` high from N+1. With `dm_ack` at cycle N+k (k≥1), `out_valid` is high in N+k+1 and `in_ready` is back in N+k+1. The minimum is 2 cycles per access.
- `in_ready` is combinational from state only. It never depends on `in_valid`.

## Configuration
- `MEM_ADDR_FAULT_EN` defined:
  - LH/LHU with `addr[0]`≠0, or LW with `addr[1:0]`≠0, sets `load_addr_fault`. SH/SW with the same conditions set `store_addr_fault`.
  - `badVaddr`=`addr`, `write_reg_out`=0, no `dm_req`, 1-cycle retire.
- Undefined:
  - Fault outputs are tied to 0 and `badVaddr` to 0.
  - Misaligned accesses proceed, with the offending low address bits forced to 0.

## Structure
- Package `mips_pkg`: `mem_op_e`, state enum, and the constants BE_BYTE/BE_HALF_LO/BE_HALF_HI/BE_WORD.
- One sub-module, `mem_lane_align`: combinational store replication with byte enables, and load lane select with extension.
- FSM and registers stay in `mem_stage`.

## Test plan
- **LB sign.** LB at `addr`=0x1003, `dm_rdata`=0x80xxxxxx, ack 1 cycle after req → `dm_be`=1000, `mem_ext_data`=0xFFFFFF80, `out_valid` 2 cycles after accept.
- **SH lane.** SH at 0x2002, `store_data`=0x0000BEEF, ack delayed 3 cycles → `dm_be`=1100, `dm_wdata`=0xBEEFBEEF held stable all 3 cycles, `write_reg_out`=0.
- **Misaligned LW.** LW at 0x3001 with `MEM_ADDR_FAULT_EN` → no `dm_req`, `load_addr_fault`=1, `badVaddr`=0x3001, `out_valid` next cycle. Without the macro → `dm_addr`=0x3000, normal load.
- **Flush in WAIT.** LW in WAIT, `flush` pulsed before ack → `dm_req` held to ack, no `out_valid`, next instruction accepted the cycle after ack.
- **Back-to-back NONE.** Non-memory ops on consecutive cycles → `out_valid` every cycle, PC/Inst passed through, `mem_ext_data`=0.
- **Reset in WAIT.** `rst_n` low in WAIT → `dm_req`=0 immediately, `in_ready`=1, all outputs 0.
